// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect/hazard controls from decode/execute, instruction
// memory port, and the F/D pipeline latch outputs.
interface fetch_if;
    logic        stall;
    logic        jump;
    logic [11:0] jump_target;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        halt;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] fd_instr;
    logic [11:0] fd_pc_plus1;
    logic        fd_valid;

    modport slave (
        input  stall, jump, jump_target, branch_taken, branch_target, halt,
        input  imem_data,
        output imem_addr, fd_instr, fd_pc_plus1, fd_valid
    );

    modport master (
        output stall, jump, jump_target, branch_taken, branch_target, halt,
        output imem_data,
        input  imem_addr, fd_instr, fd_pc_plus1, fd_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: 12-bit PC, F/D pipeline latch, and a BOOT/RUN/HALTED
// controller; redirect priority is branch_taken > jump > halt > stall.
module fetch_stage (
    input  logic    clock,
    input  logic    reset,
    fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_pc;
    logic [31:0] r_fd_instr;
    logic [11:0] r_fd_pc_plus1;
    logic        r_fd_valid;
    logic [11:0] w_pc_plus1;

    assign w_pc_plus1 = r_pc + 12'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= '0;
            r_fd_instr    <= '0;
            r_fd_pc_plus1 <= '0;
            r_fd_valid    <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (bus.branch_taken || bus.jump) begin
                        // Redirect wins over halt; halt takes effect on a later cycle.
                        r_pc          <= bus.branch_taken ? bus.branch_target : bus.jump_target;
                        r_fd_instr    <= '0;
                        r_fd_pc_plus1 <= '0;
                        r_fd_valid    <= 1'b0;
                    end else if (bus.halt) begin
                        r_state       <= HALTED;
                        r_fd_instr    <= '0;
                        r_fd_pc_plus1 <= '0;
                        r_fd_valid    <= 1'b0;
                    end else if (!bus.stall) begin
                        r_pc          <= w_pc_plus1;
                        r_fd_instr    <= bus.imem_data;
                        r_fd_pc_plus1 <= w_pc_plus1;
                        r_fd_valid    <= 1'b1;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.fd_instr    = r_fd_instr;
    assign bus.fd_pc_plus1 = r_fd_pc_plus1;
    assign bus.fd_valid    = r_fd_valid;

endmodule
